// File: rtl/lift_car_plant.sv
`default_nettype none
// ============================================================================
// Module      : lift_car_plant
// Description : Cycle-accurate car-side plant for the lift controller: car
//               position, one-hot floor sensing, door stroke and fault flags.
// Revision    : 1.0 - initial release
// ============================================================================
module lift_car_plant #(
    parameter int N_FLOORS      = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 8,
    parameter int RESET_FLOOR   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        direction,
    input  logic                        motion,
    input  logic                        door_rqst,
    output logic [N_FLOORS-1:0]         floor_sense,
    output logic [$clog2(N_FLOORS)-1:0] car_floor,
    output logic                        door_closed,
    output logic                        door_open,
    output logic                        interlock_err,
    output logic                        overtravel_err
);

    localparam int FW = $clog2(N_FLOORS);
    localparam int SW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    localparam logic [FW-1:0]       c_top_floor   = FW'(N_FLOORS - 1);
    localparam logic [FW-1:0]       c_reset_floor = FW'(RESET_FLOOR);
    localparam logic [SW-1:0]       c_seg_last    = SW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]       c_door_load   = DW'(DOOR_CYCLES - 1);
    localparam logic [N_FLOORS-1:0] c_sense_one   = N_FLOORS'(1);

    typedef enum logic [1:0] {
        S_CLOSED  = 2'd0,
        S_OPENING = 2'd1,
        S_OPEN    = 2'd2,
        S_CLOSING = 2'd3
    } door_state_t;

    door_state_t         r_door, w_door;
    logic [FW-1:0]       r_floor, w_floor;
    logic [SW-1:0]       r_seg, w_seg;
    logic [DW-1:0]       r_dcnt, w_dcnt;
    logic                r_ilk, w_ilk;
    logic                r_ot, w_ot;
    logic [N_FLOORS-1:0] r_sense, w_sense;
    logic                r_door_closed, r_door_open;
    logic                w_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_door        <= S_CLOSED;
            r_floor       <= c_reset_floor;
            r_seg         <= '0;
            r_dcnt        <= '0;
            r_ilk         <= 1'b0;
            r_ot          <= 1'b0;
            r_sense       <= c_sense_one << c_reset_floor;
            r_door_closed <= 1'b1;
            r_door_open   <= 1'b0;
        end else begin
            r_door        <= w_door;
            r_floor       <= w_floor;
            r_seg         <= w_seg;
            r_dcnt        <= w_dcnt;
            r_ilk         <= w_ilk;
            r_ot          <= w_ot;
            r_sense       <= w_sense;
            r_door_closed <= (w_door == S_CLOSED);
            r_door_open   <= (w_door == S_OPEN);
        end
    end

    always_comb begin
        w_door  = r_door;
        w_floor = r_floor;
        w_seg   = r_seg;
        w_dcnt  = r_dcnt;
        w_ilk   = r_ilk;
        w_ot    = r_ot;
        w_level = (r_seg == '0);

        // Motion is only honoured with the door fully closed; a commanded
        // step past either end of the shaft is refused and flagged.
        if (motion) begin
            if (r_door != S_CLOSED) begin
                w_ilk = 1'b1;
            end else if (direction) begin
                if (w_level && (r_floor == c_top_floor)) begin
                    w_ot = 1'b1;
                end else if (r_seg == c_seg_last) begin
                    w_seg   = '0;
                    w_floor = r_floor + 1'b1;
                end else begin
                    w_seg = r_seg + 1'b1;
                end
            end else begin
                if (w_level && (r_floor == '0)) begin
                    w_ot = 1'b1;
                end else if (w_level) begin
                    w_seg   = c_seg_last;
                    w_floor = r_floor - 1'b1;
                end else begin
                    w_seg = r_seg - 1'b1;
                end
            end
        end

        case (r_door)
            S_CLOSED: begin
                if (door_rqst && !motion && w_level) begin
                    w_door = S_OPENING;
                    w_dcnt = c_door_load;
                end
            end
            S_OPENING: begin
                if (r_dcnt == '0) w_door = S_OPEN;
                else              w_dcnt = r_dcnt - 1'b1;
            end
            S_OPEN: begin
                if (!door_rqst) begin
                    w_door = S_CLOSING;
                    w_dcnt = c_door_load;
                end
            end
            S_CLOSING: begin
                if (door_rqst) begin
                    w_door = S_OPENING;
                    w_dcnt = c_door_load;
                end else if (r_dcnt == '0) begin
                    w_door = S_CLOSED;
                end else begin
                    w_dcnt = r_dcnt - 1'b1;
                end
            end
            default: w_door = S_CLOSED;
        endcase

        w_sense = (w_seg == '0) ? (c_sense_one << w_floor) : '0;
    end

    assign floor_sense    = r_sense;
    assign car_floor      = r_floor;
    assign door_closed    = r_door_closed;
    assign door_open      = r_door_open;
    assign interlock_err  = r_ilk;
    assign overtravel_err = r_ot;

endmodule
`default_nettype wire

// File: tb/tb_lift_car_plant.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_car_plant
// Description : Directed and randomized bench for lift_car_plant against a
//               linear-position / stroke-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_car_plant;

    localparam int N  = 8;
    localparam int T  = 16;
    localparam int D  = 8;
    localparam int RF = 0;

    localparam int M_CLOSED  = 0;
    localparam int M_OPENING = 1;
    localparam int M_OPEN    = 2;
    localparam int M_CLOSING = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       direction;
    logic       motion;
    logic       door_rqst;
    logic [7:0] floor_sense;
    logic [2:0] car_floor;
    logic       door_closed;
    logic       door_open;
    logic       interlock_err;
    logic       overtravel_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: absolute position in travel cycles, door phase with
    // cycles left in the current stroke, and the two sticky faults.
    int m_pos;
    int m_door;
    int m_left;
    bit m_ilk;
    bit m_ot;

    always #5 clk = ~clk;

    lift_car_plant #(
        .N_FLOORS     (N),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D),
        .RESET_FLOOR  (RF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .direction     (direction),
        .motion        (motion),
        .door_rqst     (door_rqst),
        .floor_sense   (floor_sense),
        .car_floor     (car_floor),
        .door_closed   (door_closed),
        .door_open     (door_open),
        .interlock_err (interlock_err),
        .overtravel_err(overtravel_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_sense();
        logic [7:0] one;
        one = 8'h01;
        return (m_pos % T == 0) ? (one << (m_pos / T)) : 8'h00;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "/sense"},  {24'h0, floor_sense},   {24'h0, exp_sense()});
        check({tag, "/floor"},  {29'h0, car_floor},     32'(m_pos / T));
        check({tag, "/closed"}, {31'h0, door_closed},   32'(m_door == M_CLOSED));
        check({tag, "/open"},   {31'h0, door_open},     32'(m_door == M_OPEN));
        check({tag, "/ilk"},    {31'h0, interlock_err}, {31'h0, m_ilk});
        check({tag, "/ot"},     {31'h0, overtravel_err}, {31'h0, m_ot});
    endtask

    task automatic model_reset();
        m_pos  = RF * T;
        m_door = M_CLOSED;
        m_left = 0;
        m_ilk  = 1'b0;
        m_ot   = 1'b0;
    endtask

    task automatic model_cycle(input bit mot, input bit dir, input bit rqst);
        bit was_closed;
        bit level;
        was_closed = (m_door == M_CLOSED);
        level      = (m_pos % T == 0);
        case (m_door)
            M_CLOSED:  if (rqst && !mot && level) begin m_door = M_OPENING; m_left = D; end
            M_OPENING: begin m_left--; if (m_left == 0) m_door = M_OPEN; end
            M_OPEN:    if (!rqst) begin m_door = M_CLOSING; m_left = D; end
            default: begin
                if (rqst) begin
                    m_door = M_OPENING; m_left = D;
                end else begin
                    m_left--;
                    if (m_left == 0) m_door = M_CLOSED;
                end
            end
        endcase
        if (mot) begin
            if (!was_closed)                  m_ilk = 1'b1;
            else if (dir && m_pos == (N-1)*T) m_ot  = 1'b1;
            else if (dir)                     m_pos = m_pos + 1;
            else if (m_pos == 0)              m_ot  = 1'b1;
            else                              m_pos = m_pos - 1;
        end
    endtask

    task automatic cyc(input bit mot, input bit dir, input bit rqst, input string tag);
        motion    = mot;
        direction = dir;
        door_rqst = rqst;
        @(posedge clk);
        model_cycle(mot, dir, rqst);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int mode;
        int run;
        bit mot;
        bit dir;
        bit rqst;

        reset     = 1'b0;
        motion    = 1'b0;
        direction = 1'b0;
        door_rqst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset_sense_const", {24'h0, floor_sense}, 32'h01);
        reset = 1'b1;
        cyc(0, 0, 0, "idle");

        // Up two floors, back down one, part-segment hold and reversal.
        for (int i = 0; i < T; i++) cyc(1, 1, 0, "up_f0_f1");
        check("arrive_f1", {24'h0, floor_sense}, 32'h02);
        for (int i = 0; i < T; i++) cyc(1, 1, 0, "up_f1_f2");
        check("arrive_f2", {24'h0, floor_sense}, 32'h04);
        for (int i = 0; i < T; i++) cyc(1, 0, 0, "down_f2_f1");
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, "up_seg5");
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, "hold_mid");
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, "reverse");
        check("back_f1", {24'h0, floor_sense}, 32'h02);

        // Door stroke, hold, close, and a reopen from mid-close.
        for (int i = 0; i < D + 1; i++) cyc(0, 0, 1, "door_opening");
        check("door_open_const", {31'h0, door_open}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, "door_hold");
        for (int i = 0; i < D + 1; i++) cyc(0, 0, 0, "door_closing");
        check("door_closed_const", {31'h0, door_closed}, 32'h1);
        for (int i = 0; i < D + 1; i++) cyc(0, 0, 1, "door_reopen");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, "door_part_close");
        for (int i = 0; i < D + 2; i++) cyc(0, 0, 1, "door_reload");

        // Interlock while open; flag persists once the door has closed.
        cyc(1, 1, 1, "interlock");
        check("interlock_const", {31'h0, interlock_err}, 32'h1);
        for (int i = 0; i < D + 3; i++) cyc(0, 0, 0, "post_ilk_close");

        // Climb to the top, overtravel, then reset asynchronously mid-travel.
        for (int i = 0; i < (N - 2) * T; i++) cyc(1, 1, 0, "climb");
        check("top_sense", {24'h0, floor_sense}, 32'h80);
        cyc(1, 1, 0, "overtravel_top");
        check("overtravel_const", {31'h0, overtravel_err}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, "leave_top");
        async_reset("async_reset");
        check("async_sense_const", {24'h0, floor_sense}, 32'h01);
        cyc(1, 0, 0, "overtravel_bottom");

        // Randomized operation in bursts of a chosen command pattern.
        run  = 0;
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                mode = int'($urandom_range(0, 3));
                run  = int'($urandom_range(1, 24));
            end
            run--;
            mot  = (mode == 0) || (mode == 1);
            dir  = (mode == 0);
            rqst = (mode == 2);
            if ($urandom_range(0, 31) == 0) mot  = ~mot;
            if ($urandom_range(0, 31) == 0) rqst = ~rqst;
            if ($urandom_range(0, 31) == 0) dir  = ~dir;
            cyc(mot, dir, rqst, "random");
            if ($urandom_range(0, 249) == 0) async_reset("random_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift_car_plant.md
Name: lift_car_plant

Overview:
- Cycle-accurate behavioural responder for the lift controller's car-side interface.
- Consumes the controller's direction, motion and door_rqst commands.
- Produces the one-hot floor_sense vector and door status the controller reads back.
- Used as the closed-loop plant in top-level benches, and as the car model in FPGA demos driven by a real controller.

Parameters:
- N_FLOORS, 8, number of floors; floor 0 is the bottom floor.
- TRAVEL_CYCLES, 16, clock cycles of active motion needed to move one floor; must be >= 2.
- DOOR_CYCLES, 8, cycles for a full door open or close stroke; must be >= 1.
- RESET_FLOOR, 0, floor where the car rests after reset; must be < N_FLOORS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- direction  in  1  travel direction from controller; 1 = up, 0 = down.
- motion  in  1  1 = controller commands the car to move.
- door_rqst  in  1  1 = controller requests the door open.
- floor_sense  out  N_FLOORS  one-hot; the bit of the current floor is set only while the car is level with it; all zero between floors.
- car_floor  out  $clog2(N_FLOORS)  index of the floor at or just below the car.
- door_closed  out  1  1 only in door state CLOSED.
- door_open  out  1  1 only in door state OPEN.
- interlock_err  out  1  sticky flag: motion was commanded while the door was not closed.
- overtravel_err  out  1  sticky flag: motion was commanded beyond the top or bottom floor.

Behaviour:
- Reset state (asynchronous, all outputs registered):
  - car_floor = RESET_FLOOR, segment count seg = 0.
  - floor_sense = 1 << RESET_FLOOR.
  - Door state CLOSED: door_closed = 1, door_open = 0.
  - Both error flags = 0.
- Position encoding: pos = car_floor*TRAVEL_CYCLES + seg, with seg in 0..TRAVEL_CYCLES-1. The car is level with a floor iff seg == 0.
- A move step happens in a cycle when motion = 1, the door is CLOSED, and the step stays in range:
  - Up: pos + 1. Blocked when car_floor == N_FLOORS-1 and seg == 0.
  - Down: pos - 1. Blocked when pos == 0.
- A blocked step sets overtravel_err and the car holds position.
- When seg wraps, car_floor changes in the same cycle:
  - Up, seg T-1 -> 0: car_floor + 1.
  - Down, seg 0 -> T-1: car_floor - 1.
- floor_sense and car_floor reflect the updated position in the same registered update; there are no combinational paths from inputs to outputs.
- Starting level with floor f, TRAVEL_CYCLES consecutive up steps give floor_sense = 1 << (f+1). floor_sense drops to 0 after the first step off a floor.
- motion = 0 between floors: the car holds position and floor_sense stays 0.
- Direction reversal mid-segment is legal and takes effect on the next step.
- Door FSM, with a door counter dcnt:
  - CLOSED -> OPENING when door_rqst = 1, motion = 0 and seg == 0; dcnt loads DOOR_CYCLES-1.
  - OPENING: dcnt decrements each cycle; at dcnt == 0 go to OPEN.
  - OPEN: hold while door_rqst = 1; when door_rqst = 0 go to CLOSING and load dcnt.
  - CLOSING: decrement; at dcnt == 0 go to CLOSED.
  - door_rqst = 1 during CLOSING -> OPENING with dcnt reloaded.
- door_rqst while moving or between floors is ignored; the door stays CLOSED.
- motion = 1 and door_rqst = 1 together, level and CLOSED: motion wins. The car steps and the door stays CLOSED.
- motion = 1 while the door is not CLOSED:
  - interlock_err is set and the car does not step.
  - The door FSM continues normally.
- interlock_err and overtravel_err clear only on reset.
- Reset asserted mid-travel or mid-stroke: all state returns immediately to the reset values listed above.

Test Plan:
- Reset release at RESET_FLOOR = 0 -> floor_sense = 8'h01, car_floor = 0, door_closed = 1, both errors 0.
- Up travel: motion = 1, direction = 1 for 16 cycles from floor 0 -> floor_sense = 0 on cycles 1..15, then 8'h02 and car_floor = 1 on cycle 16. Continue 16 more -> 8'h04.
- Stop mid-travel at seg 5, hold motion = 0 for 10 cycles, then reverse with 5 down steps -> floor_sense = 0 while held, returns to 8'h02.
- Door cycle at floor 1: door_rqst = 1 with motion = 0 -> door_open = 1 after 8 cycles. Drop door_rqst -> door_closed = 1 after 8 more. Reassert door_rqst mid-CLOSING -> OPENING with full 8-cycle reload.
- Interlock: assert motion while OPEN -> interlock_err = 1 next cycle, position unchanged, flag stays 1 after the door closes.
- Overtravel: at floor 7, motion up -> overtravel_err = 1 and floor_sense stays 8'h80. Then assert reset (drive to 0) mid-travel -> floor_sense = 8'h01 and errors cleared asynchronously.
